// File: rtl/up_pkg.sv
// Fixed-point helpers shared by the DNN training datapath stages (FF, BP, UP).
// Latency: pure functions, combinational.
// Backpressure: none.
// Contents: default word format, etapos code width, and saturating
// arithmetic on a common wide signed type (calc_t). Callers sign-extend
// their operands into calc_t and narrow the result with a size cast.
package up_pkg;

   localparam int UP_WIDTH     = 12;
   localparam int UP_INT_BITS  = 3;
   localparam int UP_FRAC_BITS = UP_WIDTH - UP_INT_BITS - 1;
   // Wide enough for a full-precision width x width product plus rounding
   // headroom for any width up to 15 bits.
   localparam int UP_CALC_W    = 32;

   typedef logic signed [UP_CALC_W-1:0] calc_t;

   function automatic int up_frac_bits(input int width, input int int_bits);
      return width - int_bits - 1;
   endfunction

   // etapos must be able to encode 0..frac_bits+1.
   function automatic int up_etapos_w(input int frac_bits);
      return $clog2(frac_bits + 2);
   endfunction

   // Clamp x to the signed range of a w-bit word.
   function automatic calc_t fxp_sat(input calc_t x, input int w);
      calc_t hi;
      calc_t lo;
      hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
      lo = -hi - calc_t'(1);
      if (x > hi)      return hi;
      else if (x < lo) return lo;
      else             return x;
   endfunction

   // Negate and clamp, so that -(most negative) becomes the most positive.
   function automatic calc_t fxp_neg_sat(input calc_t x, input int w);
      return fxp_sat(-x, w);
   endfunction

   // Arithmetic right shift by s, rounding to nearest with ties away from
   // zero. For negative x the bias is half-1, so an exact -0.5 still
   // floors down to -1 while anything above it rounds towards zero.
   function automatic calc_t fxp_rshift_round(input calc_t x, input int s);
      calc_t half;
      if (s <= 0) return x;
      half = calc_t'(1) <<< (s - 1);
      if (x < 0) return (x + half - calc_t'(1)) >>> s;
      else       return (x + half) >>> s;
   endfunction

endpackage

// File: rtl/up_weight_unit.sv
// One weight lane: wt_nxt = sat(wt + sat(-sat(round(act*ed >> frac_bits)))).
// Latency: combinational; the parent registers the result.
// Backpressure: none.
// Ports: i_ed   scaled delta of the owning neuron (eta already applied)
//        i_act  activation feeding this weight
//        i_wt   current weight
//        o_wt_nxt updated weight
module up_weight_unit
   import up_pkg::*;
#(
   parameter int width     = UP_WIDTH,
   parameter int frac_bits = UP_FRAC_BITS
)(
   input  logic signed [width-1:0] i_ed,
   input  logic signed [width-1:0] i_act,
   input  logic signed [width-1:0] i_wt,
   output logic signed [width-1:0] o_wt_nxt
);

   calc_t w_prod;
   calc_t w_m;
   calc_t w_dw;
   calc_t w_sum;

   // Product keeps 2*frac_bits of fraction; round back to frac_bits.
   assign w_prod   = calc_t'(i_act) * calc_t'(i_ed);
   assign w_m      = fxp_sat(fxp_rshift_round(w_prod, frac_bits), width);
   assign w_dw     = fxp_neg_sat(w_m, width);
   assign w_sum    = calc_t'(i_wt) + w_dw;
   assign o_wt_nxt = width'(fxp_sat(w_sum, width));

endmodule

// File: rtl/up_processor_set.sv
// Update stage: z weight and z/fi bias gradient-descent steps per cycle, eta = 2^-(etapos-1).
// Latency: 1 cycle, inputs sampled every rising edge, outputs registered.
// Backpressure: none; no handshake or stall, a new set is accepted every cycle.
// Ports: clk, reset (async active-low, clears outputs), etapos (rate code),
//        act_in/wt (z lanes), del_in/bias (z/fi lanes), wt_UP/bias_UP (registered).
// etapos of 0 or above frac_bits+1 passes wt/bias through unchanged.
module up_processor_set
   import up_pkg::*;
#(
   parameter int fi        = 2,
   parameter int z         = 4,
   parameter int width     = UP_WIDTH,
   parameter int int_bits  = UP_INT_BITS,
   localparam int frac_bits = up_frac_bits(width, int_bits),
   localparam int ew        = up_etapos_w(frac_bits),
   localparam int nb        = z / fi
)(
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ew-1:0]             etapos,
   input  logic [z-1:0][width-1:0]   act_in,
   input  logic [nb-1:0][width-1:0]  del_in,
   input  logic [z-1:0][width-1:0]   wt,
   input  logic [nb-1:0][width-1:0]  bias,
   output logic [z-1:0][width-1:0]   wt_UP,
   output logic [nb-1:0][width-1:0]  bias_UP
);

   logic                     w_upd;
   int                       w_shift;
   logic [nb-1:0][width-1:0] w_ed;
   logic [nb-1:0][width-1:0] w_bias_nxt;
   logic [z-1:0][width-1:0]  w_wt_nxt;
   logic [nb-1:0][width-1:0] w_bias_d;
   logic [z-1:0][width-1:0]  w_wt_d;
   logic [z-1:0][width-1:0]  r_wt_UP;
   logic [nb-1:0][width-1:0] r_bias_UP;

   assign w_upd   = (etapos != '0) && (int'(etapos) <= frac_bits + 1);
   assign w_shift = w_upd ? int'(etapos) - 1 : 0;

   // Bias lanes: ed = round(del >>> s) cannot overflow, then bias - ed with
   // the negation and the sum each saturated.
   for (genvar j = 0; j < nb; j++) begin : g_bias
      assign w_ed[j] = width'(fxp_rshift_round(calc_t'($signed(del_in[j])), w_shift));
      assign w_bias_nxt[j] = width'(fxp_sat(calc_t'($signed(bias[j]))
                                + fxp_neg_sat(calc_t'($signed(w_ed[j])), width), width));
      assign w_bias_d[j] = w_upd ? w_bias_nxt[j] : bias[j];
   end

   // Weight i belongs to neuron i/fi and shares that neuron's scaled delta.
   for (genvar i = 0; i < z; i++) begin : g_wt
      up_weight_unit #(
         .width     (width),
         .frac_bits (frac_bits)
      ) u_wt (
         .i_ed     ($signed(w_ed[i / fi])),
         .i_act    ($signed(act_in[i])),
         .i_wt     ($signed(wt[i])),
         .o_wt_nxt (w_wt_nxt[i])
      );
      assign w_wt_d[i] = w_upd ? w_wt_nxt[i] : wt[i];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wt_UP   <= '0;
         r_bias_UP <= '0;
      end else begin
         r_wt_UP   <= w_wt_d;
         r_bias_UP <= w_bias_d;
      end
   end

   assign wt_UP   = r_wt_UP;
   assign bias_UP = r_bias_UP;

endmodule

// File: tb/tb_up_processor_set.sv
// Directed bench for up_processor_set (defaults: fi=2, z=4, Q3.8).
module tb_up_processor_set;

   localparam int W  = 12;
   localparam int Z  = 4;
   localparam int NB = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [3:0]            etapos;
   logic [Z-1:0][W-1:0]   act_in;
   logic [NB-1:0][W-1:0]  del_in;
   logic [Z-1:0][W-1:0]   wt;
   logic [NB-1:0][W-1:0]  bias;
   logic [Z-1:0][W-1:0]   wt_UP;
   logic [NB-1:0][W-1:0]  bias_UP;

   int total = 0;
   int bad   = 0;

   logic [47:0] exp_w;
   logic [23:0] exp_b;

   up_processor_set dut (
      .clk     (clk),
      .reset   (reset),
      .etapos  (etapos),
      .act_in  (act_in),
      .del_in  (del_in),
      .wt      (wt),
      .bias    (bias),
      .wt_UP   (wt_UP),
      .bias_UP (bias_UP)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference arithmetic on plain integers: round by magnitude, ties away.
   function automatic int rnd_shift(input int x, input int s);
      int mag;
      int q;
      if (s == 0) return x;
      mag = (x < 0) ? -x : x;
      q   = (mag + (1 << (s - 1))) >> s;
      return (x < 0) ? -q : q;
   endfunction

   function automatic int sat(input int x);
      if (x > 2047)  return 2047;
      if (x < -2048) return -2048;
      return x;
   endfunction

   task automatic model(input logic [3:0] eta, output logic [47:0] ew, output logic [23:0] eb);
      int s;
      int ed [NB];
      int m;
      ew = wt;
      eb = bias;
      if (eta != 0 && eta <= 9) begin
         s = int'(eta) - 1;
         for (int j = 0; j < NB; j++) begin
            ed[j] = rnd_shift(int'($signed(del_in[j])), s);
            eb[j*W +: W] = 12'(sat(int'($signed(bias[j])) + sat(-ed[j])));
         end
         for (int i = 0; i < Z; i++) begin
            m = sat(rnd_shift(int'($signed(act_in[i])) * ed[i/2], 8));
            ew[i*W +: W] = 12'(sat(int'($signed(wt[i])) + sat(-m)));
         end
      end
   endtask

   // Drive at the falling edge, let one rising edge register, sample 1 later.
   task automatic apply(input logic [3:0] eta, input logic [23:0] d, input logic [47:0] a,
                        input logic [47:0] w, input logic [23:0] b);
      @(negedge clk);
      etapos = eta;
      del_in = d;
      act_in = a;
      wt     = w;
      bias   = b;
      @(posedge clk);
      #1;
   endtask

   initial begin
      etapos = 4'd5;
      del_in = {12'h123, 12'h456};
      act_in = {12'h111, 12'h222, 12'h333, 12'h444};
      wt     = {12'h555, 12'h666, 12'h777, 12'h888};
      bias   = {12'h999, 12'hAAA};

      // Reset held across a rising edge.
      #12;
      check("reset_wt", 48'(wt_UP), 48'h0);
      check("reset_bias", 48'(bias_UP), 48'h0);

      // Release with etapos=0: pass-through.
      @(negedge clk);
      reset = 1'b1;
      apply(4'd0, {12'h3FF, 12'hC00}, {12'h100, 12'h100, 12'h100, 12'h100},
            {12'h123, 12'h456, 12'h789, 12'hABC}, {12'h3FF, 12'hC00});
      check("bypass0_wt", 48'(wt_UP), 48'h123_456_789_ABC);
      check("bypass0_bias", 48'(bias_UP), 48'h3FF_C00);

      // etapos=5: ties-away rounding of -0.5 and -1.5 LSB.
      apply(4'd5, {12'hFF8, 12'h400}, {12'h180, 12'h100, 12'h080, 12'h000},
            {12'hD00, 12'hE00, 12'hF00, 12'h000}, {12'h800, 12'h040});
      check("eta5_wt", 48'(wt_UP), 48'hD02_E01_EE0_000);
      check("eta5_bias", 48'(bias_UP), 48'h801_000);

      // etapos=0 with the same operands: no update.
      apply(4'd0, {12'hFF8, 12'h400}, {12'h180, 12'h100, 12'h080, 12'h000},
            {12'hD00, 12'hE00, 12'hF00, 12'h000}, {12'h801, 12'h000});
      check("eta0_wt", 48'(wt_UP), 48'hD00_E00_F00_000);
      check("eta0_bias", 48'(bias_UP), 48'h801_000);

      // etapos=1: negation of 0x800 saturates, sums saturate.
      apply(4'd1, {12'h000, 12'h800}, {12'h100, 12'h100, 12'h100, 12'h100},
            {12'hD00, 12'hE00, 12'hF00, 12'h000}, {12'h801, 12'h000});
      check("eta1_wt", 48'(wt_UP), 48'hD00_E00_6FF_7FF);
      check("eta1_bias", 48'(bias_UP), 48'h801_7FF);

      // etapos=9: largest shift, extreme operands, saturation at both ends.
      apply(4'd9, {12'h100, 12'h7FF}, {12'h100, 12'h800, 12'h7FF, 12'h7FF},
            {12'h000, 12'h7FF, 12'h000, 12'h800}, {12'h7FF, 12'h000});
      check("eta9_wt", 48'(wt_UP), 48'hFFF_7FF_FC0_800);
      check("eta9_bias", 48'(bias_UP), 48'h7FE_FF8);
      model(4'd9, exp_w, exp_b);
      check("eta9_wt_model", 48'(wt_UP), exp_w);
      check("eta9_bias_model", 48'(bias_UP), 48'(exp_b));

      // etapos=10 is beyond frac_bits+1: pass-through.
      apply(4'd10, {12'h100, 12'h7FF}, {12'h100, 12'h800, 12'h7FF, 12'h7FF},
            {12'h000, 12'h7FF, 12'h000, 12'h800}, {12'h7FF, 12'h000});
      check("eta10_wt", 48'(wt_UP), 48'h000_7FF_000_800);
      check("eta10_bias", 48'(bias_UP), 48'h7FF_000);

      // etapos=3 on mixed-sign operands against the reference model.
      apply(4'd3, {12'hC35, 12'h1FE}, {12'h7FF, 12'hA00, 12'h0C0, 12'hF81},
            {12'h100, 12'h800, 12'h7F0, 12'hFFF}, {12'h800, 12'h7FF});
      model(4'd3, exp_w, exp_b);
      check("eta3_wt_model", 48'(wt_UP), exp_w);
      check("eta3_bias_model", 48'(bias_UP), 48'(exp_b));

      // Asynchronous reset between edges, then recovery on the next edge.
      @(negedge clk);
      etapos = 4'd5;
      del_in = {12'hFF8, 12'h400};
      act_in = {12'h180, 12'h100, 12'h080, 12'h000};
      wt     = {12'hD00, 12'hE00, 12'hF00, 12'h000};
      bias   = {12'h800, 12'h040};
      #2;
      reset = 1'b0;
      #1;
      check("midrst_wt", 48'(wt_UP), 48'h0);
      check("midrst_bias", 48'(bias_UP), 48'h0);
      @(negedge clk);
      check("midrst_hold_wt", 48'(wt_UP), 48'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("release_wt", 48'(wt_UP), 48'hD02_E01_EE0_000);
      check("release_bias", 48'(bias_UP), 48'h801_000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
